// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg
// Shared definitions for the ROM access arbiter and its priority picker:
//   - arb_state_t : access sequencer state encodings
//   - clog2       : ceiling log2, usable in constant (parameter) expressions
//   - idx_width   : width of an index into a vector of n entries (at least 1)
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // A one-entry (or two-entry) vector still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rom_access_arbiter_if.sv
// rom_access_arbiter_if
// Requester-side bundle of the ROM access arbiter.
//   req   : level request per requester, held until its ack
//   addr  : flattened addresses, requester i in [i*ADDR_WIDTH +: ADDR_WIDTH]
//   ack   : one-hot, one-cycle completion pulse
//   rdata : data of the most recent completed access
// Modports:
//   master : the requesters (fetch logic / CPUs)
//   slave  : the arbiter
interface rom_access_arbiter_if #(
    parameter int NREQ       = 4,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
);
    logic [NREQ-1:0]            req;
    logic [NREQ*ADDR_WIDTH-1:0] addr;
    logic [NREQ-1:0]            ack;
    logic [DATA_WIDTH-1:0]      rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/rr_priority_picker.sv
// rr_priority_picker
// Combinational round-robin picker. Searches req upward starting at
// last_grant+1 and wrapping at NREQ.
//   req        in  NREQ  request vector
//   last_grant in  IDXW  index of the most recently served requester
//   grant      out IDXW  chosen requester (meaningful only when valid)
//   valid      out 1     at least one request present
module rr_priority_picker
    import rom_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_grant,
    output logic [IDXW-1:0] grant,
    output logic            valid
);

    // Requesters strictly above last_grant get first pick; if none of them
    // is asking, the search wraps to the lowest requesting index.
    logic [NREQ-1:0] upper_mask;
    logic [NREQ-1:0] req_upper;
    logic [IDXW-1:0] grant_upper;
    logic [IDXW-1:0] grant_any;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi = gi + 1) begin : g_mask
            assign upper_mask[gi] = (IDXW'(gi) > last_grant);
        end
    endgenerate

    assign req_upper = req & upper_mask;

    // Scan downward so the lowest set index is the one left standing.
    always_comb begin
        grant_upper = '0;
        grant_any   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_upper[i]) begin
                grant_upper = IDXW'(i);
            end
            if (req[i]) begin
                grant_any = IDXW'(i);
            end
        end
    end

    assign grant = (|req_upper) ? grant_upper : grant_any;
    assign valid = |req;

endmodule

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter
// Shares one asynchronous EPROM between NREQ synchronous requesters.
// Picks a requester round-robin, holds CEn/OEn low with a frozen address for
// WAIT_CYCLES cycles, registers the ROM data and pulses that requester's ack.
// A one-cycle RELEASE follows each access for bus turnaround.
//   clk      in  1           system clock
//   rst      in  1           synchronous active-high reset
//   bus      slave modport   req / addr / ack / rdata
//   rom_addr out ADDR_WIDTH  registered ROM address
//   rom_cen  out 1           ROM chip enable, active low
//   rom_oen  out 1           ROM output enable, active low
//   rom_data in  DATA_WIDTH  ROM data bus (may be X/Z while disabled)
module rom_access_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int ADDR_WIDTH  = 15,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    rom_access_arbiter_if.slave   bus,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_cen,
    output logic                  rom_oen,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    localparam int IDXW = idx_width(NREQ);
    localparam int CNTW = clog2(WAIT_CYCLES) + 1;

    arb_state_t            state_reg;
    arb_state_t            state_next;
    logic [CNTW-1:0]       cnt_reg;
    logic [IDXW-1:0]       grant_reg;
    logic [IDXW-1:0]       last_grant_reg;
    logic [ADDR_WIDTH-1:0] rom_addr_reg;
    logic                  rom_cen_reg;
    logic                  rom_oen_reg;
    logic [NREQ-1:0]       ack_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;

    logic [IDXW-1:0]       pick_grant;
    logic                  pick_valid;
    logic                  start_access;
    logic                  finish_access;

    logic [ADDR_WIDTH-1:0] addr_slice [NREQ];
    logic [NREQ-1:0]       grant_onehot;

    // Unpack the flattened address bus and decode the held grant to one-hot.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi = gi + 1) begin : g_req
            assign addr_slice[gi]   = bus.addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign grant_onehot[gi] = (grant_reg == IDXW'(gi));
        end
    endgenerate

    rr_priority_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_picker (
        .req        (bus.req),
        .last_grant (last_grant_reg),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_valid) state_next = ACCESS;
            ACCESS:  if (cnt_reg == '0) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/control decode for the datapath registers
    always_comb begin
        start_access  = 1'b0;
        finish_access = 1'b0;
        case (state_reg)
            IDLE:    start_access  = pick_valid;
            ACCESS:  finish_access = (cnt_reg == '0);
            default: ;
        endcase
    end

    // Datapath: counter, frozen grant/address, ROM strobes, data and ack.
    // rom_data is captured only on the finishing edge, so bus float while the
    // ROM is disabled never reaches rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg        <= '0;
            grant_reg      <= '0;
            last_grant_reg <= IDXW'(NREQ - 1);
            rom_addr_reg   <= '0;
            rom_cen_reg    <= 1'b1;
            rom_oen_reg    <= 1'b1;
            ack_reg        <= '0;
            rdata_reg      <= '0;
        end else begin
            ack_reg <= '0;
            if (start_access) begin
                grant_reg    <= pick_grant;
                rom_addr_reg <= addr_slice[pick_grant];
                rom_cen_reg  <= 1'b0;
                rom_oen_reg  <= 1'b0;
                cnt_reg      <= CNTW'(WAIT_CYCLES - 1);
            end
            if (state_reg == ACCESS && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - CNTW'(1);
            end
            if (finish_access) begin
                rdata_reg      <= rom_data;
                ack_reg        <= grant_onehot;
                last_grant_reg <= grant_reg;
                rom_cen_reg    <= 1'b1;
                rom_oen_reg    <= 1'b1;
            end
        end
    end

    assign rom_addr  = rom_addr_reg;
    assign rom_cen   = rom_cen_reg;
    assign rom_oen   = rom_oen_reg;
    assign bus.ack   = ack_reg;
    assign bus.rdata = rdata_reg;

endmodule
